// File: rtl/led_status.sv
// rtl/led_status.sv - per-channel status-to-LED mode encoder with stretched activity/error holds
// Optional per-channel override table compiled in with LED_STATUS_OVERRIDE_EN.
module led_status #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int ACT_HOLD_MS   = 200,
    parameter int ERR_HOLD_MS   = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] link_up,
    input  logic [15:0] act_pulse,
    input  logic [15:0] err_pulse,
    input  logic        ovr_wr,
    input  logic [3:0]  ovr_idx,
    input  logic        ovr_en,
    input  logic [1:0]  ovr_mode,
    output logic [31:0] led_mode,
    output logic        tick
);
    localparam int TICK_DIV = 1000000 / CLK_PERIOD_NS;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW       = $clog2(ERR_HOLD_MS + 1);
    localparam int AW       = $clog2(ACT_HOLD_MS + 1);

    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [EW-1:0] ERR_LOAD = EW'(ERR_HOLD_MS);
    localparam logic [AW-1:0] ACT_LOAD = AW'(ACT_HOLD_MS);

    logic [PW-1:0]        pre_cnt;
    logic [PW-1:0]        pre_next;
    logic [15:0][EW-1:0]  err_cnt;
    logic [15:0][EW-1:0]  err_next;
    logic [15:0][AW-1:0]  act_cnt;
    logic [15:0][AW-1:0]  act_next;
    logic [31:0]          mode_next;

`ifdef LED_STATUS_OVERRIDE_EN
    logic [15:0]          ovr_en_q;
    logic [15:0][1:0]     ovr_mode_q;

    // Table is written at the same edge as the strobe; led_mode picks it up one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_en_q   <= '0;
            ovr_mode_q <= '0;
        end else if (ovr_wr) begin
            ovr_en_q[ovr_idx]   <= ovr_en;
            ovr_mode_q[ovr_idx] <= ovr_mode;
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr = ^{ovr_wr, ovr_idx, ovr_en, ovr_mode};
`endif

    always_comb begin
        pre_next = (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PW'(1);
    end

    // tick is high while the prescaler sits at its last count, so it doubles as the decrement enable.
    always_comb begin
        err_next  = err_cnt;
        act_next  = act_cnt;
        mode_next = '0;
        for (int n = 0; n < 16; n++) begin
            if (err_pulse[n])
                err_next[n] = ERR_LOAD;
            else if (tick && (err_cnt[n] != '0))
                err_next[n] = err_cnt[n] - EW'(1);

            if (act_pulse[n])
                act_next[n] = ACT_LOAD;
            else if (tick && (act_cnt[n] != '0))
                act_next[n] = act_cnt[n] - AW'(1);

            if (err_next[n] != '0)
                mode_next[2*n +: 2] = 2'b01;
            else if (act_next[n] != '0)
                mode_next[2*n +: 2] = 2'b10;
            else if (link_up[n])
                mode_next[2*n +: 2] = 2'b11;
            else
                mode_next[2*n +: 2] = 2'b00;

`ifdef LED_STATUS_OVERRIDE_EN
            if (ovr_en_q[n])
                mode_next[2*n +: 2] = ovr_mode_q[n];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt  <= '0;
            tick     <= 1'b0;
            err_cnt  <= '0;
            act_cnt  <= '0;
            led_mode <= '0;
        end else begin
            pre_cnt  <= pre_next;
            tick     <= (pre_next == PRE_MAX);
            err_cnt  <= err_next;
            act_cnt  <= act_next;
            led_mode <= mode_next;
        end
    end
endmodule
